veer_trace_sink: RTL and testbench
==================================

Name: veer_trace_sink

Overview:
- Consumer end of the core's per-cycle retirement trace bundle (trace_pkt_t).
- Each cycle, takes up to three retired-instruction slots and unrolls them into one record per instruction, in slot order.
- Records are buffered in a FIFO and drained on a valid/ready stream toward a debug trace port or trace memory.
- The core cannot be back-pressured, so overflow is handled by all-or-nothing packet drop with a drop counter and an overflow marker.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, >=4).
- DCNT_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  core clock
- rst_l  input  1  asynchronous active-low reset
- trace_en  input  1  capture enable
- trace_rv_i_valid_ip  input  3  per-slot retire valid, slot s = bit s
- trace_rv_i_insn_ip  input  96  slot s instruction = bits [32s+31:32s]
- trace_rv_i_address_ip  input  96  slot s PC, same packing
- trace_rv_i_exception_ip  input  3  per-slot exception flag
- trace_rv_i_ecause_ip  input  5  shared cause
- trace_rv_i_interrupt_ip  input  3  per-slot interrupt flag
- trace_rv_i_tval_ip  input  32  shared trap value
- tr_valid  output  1  head record valid
- tr_ready  input  1  sink accepts
- tr_insn  output  32  record instruction
- tr_addr  output  32  record PC
- tr_slot  output  2  originating slot
- tr_exc  output  1  exception flag
- tr_intr  output  1  interrupt flag
- tr_ecause  output  5  cause; 0 unless tr_exc or tr_intr
- tr_tval  output  32  tval; 0 unless tr_exc or tr_intr
- tr_ovf  output  1  one or more packets were dropped immediately before this record
- drop_cnt  output  DCNT_W  dropped-packet count, saturating
- fifo_cnt  output  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: all outputs 0; FIFO empty; pointers 0; sticky overflow flag (ovf_pend) 0.
- Capture:
  - n = popcount(valid_ip & {3{trace_en}}).
  - free = DEPTH - fifo_cnt, taken from the start-of-cycle count. A same-cycle pop gives no credit.
  - If n > 0 and n <= free: write n records in ascending slot order into consecutive entries (wrap modulo DEPTH); wptr += n.
  - If n > free: drop the whole packet, write nothing, drop_cnt += 1 (holds at all-ones), set ovf_pend.
  - n = 0 or trace_en = 0: no write, no count.
- Record fields:
  - insn and addr come from the slot's packed slice; slot = s.
  - exc and intr are the slot's bits.
  - ecause and tval are copied only when the slot's exc or intr bit is set; otherwise 0.
  - Exception and interrupt both set on one slot: both flags recorded, and the cause is still copied.
- ovf marker: the first record written after ovf_pend is set carries tr_ovf = 1 (first slot of that packet only). ovf_pend clears in the same cycle. A drop and a successful write cannot occur in the same cycle.
- Output:
  - tr_valid = (fifo_cnt != 0); record fields are driven directly from the head entry.
  - Pop occurs when tr_valid & tr_ready; rptr += 1.
  - When tr_valid = 0, the record fields hold the last head entry contents and have no meaning.
  - Stream rule: once tr_valid is asserted, it stays asserted and the head record stays stable until accepted.
- Latency: a record captured in cycle t is visible on tr_* in cycle t+1 if the FIFO was empty.
- Push and pop in the same cycle: fifo_cnt_next = fifo_cnt + n - pop. Full FIFO with pop and n = 1: the packet is dropped, because free is computed before the pop.
- trace_en deassert mid-stream: FIFO keeps draining; ovf_pend and drop_cnt are retained.
- Reset mid-operation: FIFO contents are discarded immediately; tr_valid falls asynchronously.

Decomposition:
- Shared package veer_types: add trace_rec_t (insn, addr, slot, exc, intr, ecause, tval, ovf; 106 bits); the block reuses the existing trace_pkt_t.
- One sub-module, veer_trace_fifo: multi-write (up to 3) / single-read circular buffer.
  - Inputs: wr_cnt, wr_data[3], rd.
  - Outputs: head, count.
- Unroll, compaction and drop logic stay in the top module.

Test Plan:
- Single slot: reset, trace_en=1, valid_ip=3'b001, insn=0x00000013, addr=0x80000000 -> next cycle tr_valid=1, tr_insn=0x13, tr_addr=0x80000000, tr_slot=0, tr_ecause=0, tr_tval=0.
- Compaction: valid_ip=3'b101, insn slots {0xA,0xB,0xC}, tr_ready=1 -> two records in order: slot 0 insn 0xA, then slot 2 insn 0xC; fifo_cnt peaks at 2.
- Exception: valid_ip=3'b011, exception_ip=3'b010, ecause=5'd2, tval=0xDEAD -> slot 0 record has ecause=0, tval=0; slot 1 record has exc=1, ecause=2, tval=0xDEAD.
- Overflow (DEPTH=8, tr_ready=0):
  - Push packets of 3, 3, 2 -> full.
  - Push 1 more -> drop_cnt=1, fifo_cnt=8.
  - Raise tr_ready, drain 1, push valid_ip=3'b001 -> that record has tr_ovf=1, and the following record has tr_ovf=0.
- Full with simultaneous pop: FIFO full, tr_ready=1, valid_ip=3'b001 -> packet dropped, fifo_cnt=7.
- Saturation and reset: force 2^DCNT_W+3 drops -> drop_cnt=0xFFFF. Assert rst_l=0 mid-stream -> tr_valid=0, drop_cnt=0, fifo_cnt=0 without a clock edge.

Source files
------------

// File: rtl/veer_trace_sink_pkg.sv
// Shared types for the retirement trace sink: the core's per-cycle trace bundle,
// the unrolled per-instruction record, and the helpers that build one from the other.
package veer_trace_sink_pkg;

    localparam int unsigned NumSlots = 3;

    typedef struct packed {
        logic [2:0]  valid;
        logic [95:0] insn;
        logic [95:0] address;
        logic [2:0]  exception;
        logic [4:0]  ecause;
        logic [2:0]  interrupt;
        logic [31:0] tval;
    } trace_pkt_t;

    // 106-bit record, one per retired instruction
    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic [1:0]  slot;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
        logic        ovf;
    } trace_rec_t;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Cause and tval are shared across slots, so only a trapping slot may carry them.
    function automatic trace_rec_t unroll_slot(input trace_pkt_t pkt, input int unsigned s);
        trace_rec_t rec;
        logic       trap;
        trap        = pkt.exception[s] | pkt.interrupt[s];
        rec.insn    = pkt.insn[32*s +: 32];
        rec.addr    = pkt.address[32*s +: 32];
        rec.slot    = 2'(s);
        rec.exc     = pkt.exception[s];
        rec.intr    = pkt.interrupt[s];
        rec.ecause  = trap ? pkt.ecause : 5'd0;
        rec.tval    = trap ? pkt.tval : 32'd0;
        rec.ovf     = 1'b0;
        return rec;
    endfunction

endpackage

// File: rtl/veer_trace_sink_if.sv
// Trace bundle from the core plus the valid/ready record stream toward the trace port.
interface veer_trace_sink_if;

    logic        trace_en;
    logic [2:0]  trace_rv_i_valid_ip;
    logic [95:0] trace_rv_i_insn_ip;
    logic [95:0] trace_rv_i_address_ip;
    logic [2:0]  trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic [2:0]  trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;

    logic        tr_valid;
    logic        tr_ready;
    logic [31:0] tr_insn;
    logic [31:0] tr_addr;
    logic [1:0]  tr_slot;
    logic        tr_exc;
    logic        tr_intr;
    logic [4:0]  tr_ecause;
    logic [31:0] tr_tval;
    logic        tr_ovf;

    modport master (
        output trace_en, trace_rv_i_valid_ip, trace_rv_i_insn_ip, trace_rv_i_address_ip,
               trace_rv_i_exception_ip, trace_rv_i_ecause_ip, trace_rv_i_interrupt_ip,
               trace_rv_i_tval_ip, tr_ready,
        input  tr_valid, tr_insn, tr_addr, tr_slot, tr_exc, tr_intr, tr_ecause, tr_tval, tr_ovf
    );

    modport slave (
        input  trace_en, trace_rv_i_valid_ip, trace_rv_i_insn_ip, trace_rv_i_address_ip,
               trace_rv_i_exception_ip, trace_rv_i_ecause_ip, trace_rv_i_interrupt_ip,
               trace_rv_i_tval_ip, tr_ready,
        output tr_valid, tr_insn, tr_addr, tr_slot, tr_exc, tr_intr, tr_ecause, tr_tval, tr_ovf
    );

endinterface

// File: rtl/veer_trace_fifo.sv
// Circular record buffer: up to three writes per cycle into consecutive entries, one read.
module veer_trace_fifo
    import veer_trace_sink_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic [1:0]               wr_cnt,
    input  trace_rec_t               wr_data [NumSlots],
    input  logic                     rd,
    output trace_rec_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    trace_rec_t      mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rd_ok;

    // Caller guarantees wr_cnt fits in the free space seen at the start of the cycle.
    assign rd_ok = rd & (cnt_q != '0);

    always_comb begin
        wptr_d = wptr_q + PtrW'(wr_cnt);
        rptr_d = rptr_q + PtrW'(rd_ok);
        cnt_d  = cnt_q + CntW'(wr_cnt) - CntW'(rd_ok);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NumSlots); k++) begin
                if (2'(k) < wr_cnt) begin
                    mem_q[wptr_q + PtrW'(k)] <= wr_data[k];
                end
            end
        end
    end

    assign head  = mem_q[rptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/veer_trace_sink.sv
// Retirement trace sink: compacts valid slots into records, buffers them, and drops
// whole packets (with a sticky overflow marker) when the buffer cannot take them.
module veer_trace_sink
    import veer_trace_sink_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DCNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_l,
    veer_trace_sink_if.slave       bus,
    output logic [DCNT_W-1:0]      drop_cnt,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    trace_pkt_t        pkt;
    logic [2:0]        vld;
    logic [1:0]        n;
    logic [CntW-1:0]   free;
    logic              drop;
    logic [1:0]        wr_cnt;
    logic              rd;
    trace_rec_t        wr_data [NumSlots];
    trace_rec_t        head;
    logic [DCNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              ovf_pend_q, ovf_pend_d;

    assign pkt = '{
        valid:     bus.trace_rv_i_valid_ip,
        insn:      bus.trace_rv_i_insn_ip,
        address:   bus.trace_rv_i_address_ip,
        exception: bus.trace_rv_i_exception_ip,
        ecause:    bus.trace_rv_i_ecause_ip,
        interrupt: bus.trace_rv_i_interrupt_ip,
        tval:      bus.trace_rv_i_tval_ip
    };

    assign vld  = pkt.valid & {3{bus.trace_en}};
    assign n    = popcount3(vld);
    // Free space excludes any pop happening this same cycle.
    assign free = CntW'(DEPTH) - fifo_cnt;
    assign drop = (n != 2'd0) && (CntW'(n) > free);
    assign wr_cnt = drop ? 2'd0 : n;

    // Pack valid slots into the lowest write lanes, keeping slot order.
    always_comb begin
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < int'(NumSlots); k++) begin
            wr_data[k] = '0;
        end
        for (int s = 0; s < int'(NumSlots); s++) begin
            if (vld[s]) begin
                wr_data[idx] = unroll_slot(pkt, s);
                idx          = idx + 2'd1;
            end
        end
        wr_data[0].ovf = ovf_pend_q;
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        ovf_pend_d = ovf_pend_q;
        if (drop) begin
            ovf_pend_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DCNT_W'(1);
            end
        end else if (wr_cnt != 2'd0) begin
            ovf_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            drop_cnt_q <= '0;
            ovf_pend_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            ovf_pend_q <= ovf_pend_d;
        end
    end

    veer_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .wr_cnt  (wr_cnt),
        .wr_data (wr_data),
        .rd      (rd),
        .head    (head),
        .count   (fifo_cnt)
    );

    assign rd = bus.tr_valid & bus.tr_ready;

    assign bus.tr_valid  = (fifo_cnt != '0);
    assign bus.tr_insn   = head.insn;
    assign bus.tr_addr   = head.addr;
    assign bus.tr_slot   = head.slot;
    assign bus.tr_exc    = head.exc;
    assign bus.tr_intr   = head.intr;
    assign bus.tr_ecause = head.ecause;
    assign bus.tr_tval   = head.tval;
    assign bus.tr_ovf    = head.ovf;

    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_veer_trace_sink.sv
// Directed bench for veer_trace_sink: capture, compaction, trap gating, overflow
// marker, drop-on-full-with-pop, counter saturation and asynchronous reset.
module tb_veer_trace_sink;

    logic        clk;
    logic        rst_l;
    logic [15:0] drop_cnt;
    logic [3:0]  fifo_cnt;
    int          errors;
    int          checks;

    veer_trace_sink_if bus ();

    veer_trace_sink #(
        .DEPTH  (8),
        .DCNT_W (16)
    ) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .bus      (bus),
        .drop_cnt (drop_cnt),
        .fifo_cnt (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pkt();
        bus.trace_rv_i_valid_ip     = 3'b000;
        bus.trace_rv_i_insn_ip      = '0;
        bus.trace_rv_i_address_ip   = '0;
        bus.trace_rv_i_exception_ip = 3'b000;
        bus.trace_rv_i_interrupt_ip = 3'b000;
        bus.trace_rv_i_ecause_ip    = 5'd0;
        bus.trace_rv_i_tval_ip      = 32'd0;
    endtask

    // Slot s gets insn base+s and PC 0x1000+4*(base+s); packet applied for one edge.
    task automatic push_pkt(input logic [2:0] v, input logic [31:0] base);
        for (int s = 0; s < 3; s++) begin
            bus.trace_rv_i_insn_ip[32*s +: 32]    = base + 32'(s);
            bus.trace_rv_i_address_ip[32*s +: 32] = 32'h1000 + 32'd4 * (base + 32'(s));
        end
        bus.trace_rv_i_valid_ip = v;
        tick();
        clear_pkt();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_l  = 1'b0;
        bus.trace_en = 1'b0;
        bus.tr_ready = 1'b0;
        clear_pkt();

        // Reset state
        #3;
        check("rst_valid", 32'(bus.tr_valid), 32'd0);
        check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_insn", bus.tr_insn, 32'd0);
        check("rst_ovf", 32'(bus.tr_ovf), 32'd0);
        #10;
        rst_l = 1'b1;
        bus.trace_en = 1'b1;

        // Single slot; shared cause/tval driven but must be gated off
        bus.trace_rv_i_insn_ip[31:0]    = 32'h0000_0013;
        bus.trace_rv_i_address_ip[31:0] = 32'h8000_0000;
        bus.trace_rv_i_ecause_ip        = 5'd7;
        bus.trace_rv_i_tval_ip          = 32'h1234;
        bus.trace_rv_i_valid_ip         = 3'b001;
        tick();
        clear_pkt();
        check("single_valid", 32'(bus.tr_valid), 32'd1);
        check("single_insn", bus.tr_insn, 32'h13);
        check("single_addr", bus.tr_addr, 32'h8000_0000);
        check("single_slot", 32'(bus.tr_slot), 32'd0);
        check("single_ecause", 32'(bus.tr_ecause), 32'd0);
        check("single_tval", bus.tr_tval, 32'd0);
        check("single_cnt", 32'(fifo_cnt), 32'd1);
        bus.tr_ready = 1'b1;
        tick();
        bus.tr_ready = 1'b0;
        check("single_drained", 32'(bus.tr_valid), 32'd0);

        // Compaction: slots 0 and 2 only
        bus.tr_ready = 1'b1;
        bus.trace_rv_i_insn_ip    = {32'hC, 32'hB, 32'hA};
        bus.trace_rv_i_address_ip = {32'h108, 32'h104, 32'h100};
        bus.trace_rv_i_valid_ip   = 3'b101;
        tick();
        clear_pkt();
        check("cmp_cnt_peak", 32'(fifo_cnt), 32'd2);
        check("cmp_first_insn", bus.tr_insn, 32'hA);
        check("cmp_first_slot", 32'(bus.tr_slot), 32'd0);
        tick();
        check("cmp_second_insn", bus.tr_insn, 32'hC);
        check("cmp_second_slot", 32'(bus.tr_slot), 32'd2);
        check("cmp_second_addr", bus.tr_addr, 32'h108);
        check("cmp_cnt_1", 32'(fifo_cnt), 32'd1);
        tick();
        bus.tr_ready = 1'b0;
        check("cmp_empty", 32'(fifo_cnt), 32'd0);

        // Exception on slot 1 only
        bus.trace_rv_i_insn_ip[63:0]  = {32'h22, 32'h11};
        bus.trace_rv_i_valid_ip       = 3'b011;
        bus.trace_rv_i_exception_ip   = 3'b010;
        bus.trace_rv_i_ecause_ip      = 5'd2;
        bus.trace_rv_i_tval_ip        = 32'hDEAD;
        tick();
        clear_pkt();
        check("exc_s0_exc", 32'(bus.tr_exc), 32'd0);
        check("exc_s0_ecause", 32'(bus.tr_ecause), 32'd0);
        check("exc_s0_tval", bus.tr_tval, 32'd0);
        bus.tr_ready = 1'b1;
        tick();
        check("exc_s1_insn", bus.tr_insn, 32'h22);
        check("exc_s1_exc", 32'(bus.tr_exc), 32'd1);
        check("exc_s1_intr", 32'(bus.tr_intr), 32'd0);
        check("exc_s1_ecause", 32'(bus.tr_ecause), 32'd2);
        check("exc_s1_tval", bus.tr_tval, 32'hDEAD);
        tick();
        check("exc_empty", 32'(fifo_cnt), 32'd0);

        // Exception and interrupt together on slot 2
        bus.trace_rv_i_valid_ip     = 3'b100;
        bus.trace_rv_i_exception_ip = 3'b100;
        bus.trace_rv_i_interrupt_ip = 3'b100;
        bus.trace_rv_i_ecause_ip    = 5'd11;
        bus.trace_rv_i_tval_ip      = 32'hBEEF;
        bus.tr_ready = 1'b0;
        tick();
        clear_pkt();
        check("both_exc", 32'(bus.tr_exc), 32'd1);
        check("both_intr", 32'(bus.tr_intr), 32'd1);
        check("both_ecause", 32'(bus.tr_ecause), 32'd11);
        check("both_tval", bus.tr_tval, 32'hBEEF);
        bus.tr_ready = 1'b1;
        tick();
        bus.tr_ready = 1'b0;

        // Overflow: 3+3+2 fills, next packet dropped
        push_pkt(3'b111, 32'h100);
        push_pkt(3'b111, 32'h110);
        push_pkt(3'b011, 32'h120);
        check("ovf_full", 32'(fifo_cnt), 32'd8);
        push_pkt(3'b001, 32'h130);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
        check("ovf_cnt_held", 32'(fifo_cnt), 32'd8);
        check("ovf_head_insn", bus.tr_insn, 32'h100);
        check("ovf_head_flag", 32'(bus.tr_ovf), 32'd0);
        bus.tr_ready = 1'b1;
        tick();
        check("ovf_drain1_cnt", 32'(fifo_cnt), 32'd7);
        check("ovf_drain1_head", bus.tr_insn, 32'h101);
        push_pkt(3'b001, 32'h77);
        check("ovf_push_pop_cnt", 32'(fifo_cnt), 32'd7);
        push_pkt(3'b001, 32'h88);
        check("ovf_head_after", bus.tr_insn, 32'h110);
        for (int i = 0; i < 5; i++) tick();
        check("ovf_mark_insn", bus.tr_insn, 32'h77);
        check("ovf_mark_flag", 32'(bus.tr_ovf), 32'd1);
        check("ovf_mark_cnt", 32'(fifo_cnt), 32'd2);
        tick();
        check("ovf_next_insn", bus.tr_insn, 32'h88);
        check("ovf_next_flag", 32'(bus.tr_ovf), 32'd0);
        tick();
        check("ovf_empty", 32'(bus.tr_valid), 32'd0);

        // Full with simultaneous pop: still dropped
        bus.tr_ready = 1'b0;
        push_pkt(3'b111, 32'h200);
        push_pkt(3'b111, 32'h210);
        push_pkt(3'b011, 32'h220);
        bus.tr_ready = 1'b1;
        push_pkt(3'b001, 32'h230);
        check("fullpop_cnt", 32'(fifo_cnt), 32'd7);
        check("fullpop_drop_cnt", 32'(drop_cnt), 32'd2);
        check("fullpop_head", bus.tr_insn, 32'h201);

        // Saturation: keep full and drop 2^16+3 packets
        bus.tr_ready = 1'b0;
        push_pkt(3'b001, 32'h240);
        check("sat_full", 32'(fifo_cnt), 32'd8);
        bus.trace_rv_i_valid_ip = 3'b001;
        for (int i = 0; i < 65539; i++) tick();
        clear_pkt();
        check("sat_drop_cnt", 32'(drop_cnt), 32'hFFFF);
        check("sat_cnt", 32'(fifo_cnt), 32'd8);
        check("sat_head_stable", bus.tr_insn, 32'h201);

        // Asynchronous reset mid-stream, away from any clock edge
        #2;
        rst_l = 1'b0;
        #1;
        check("arst_valid", 32'(bus.tr_valid), 32'd0);
        check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("arst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("arst_insn", bus.tr_insn, 32'd0);
        #3;
        rst_l = 1'b1;

        // Capture disabled: nothing written
        bus.trace_en = 1'b0;
        push_pkt(3'b111, 32'h300);
        check("dis_cnt", 32'(fifo_cnt), 32'd0);
        check("dis_drop_cnt", 32'(drop_cnt), 32'd0);
        bus.trace_en = 1'b1;
        push_pkt(3'b001, 32'h310);
        check("post_rst_insn", bus.tr_insn, 32'h310);
        check("post_rst_ovf", 32'(bus.tr_ovf), 32'd0);
        check("post_rst_cnt", 32'(fifo_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
